// File: rtl/transform_pkg.sv
// Shared definitions for the 4x4 inverse-transform sequencer and its register file.
package transform_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DCFILL = 3'd1;
  localparam logic [2:0] ST_IQ     = 3'd2;
  localparam logic [2:0] ST_COL    = 3'd3;
  localparam logic [2:0] ST_ROW    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam int PHASE_LEN = 4;

  // Block type codes, interpreted identically by the register file.
  localparam logic [2:0] BLK_LUMA_AC   = 3'd0;
  localparam logic [2:0] BLK_LUMA_4X4  = 3'd1;
  localparam logic [2:0] BLK_LUMA_DC   = 3'd2;
  localparam logic [2:0] BLK_CB_DC     = 3'd3;
  localparam logic [2:0] BLK_CR_DC     = 3'd4;
  localparam logic [2:0] BLK_CB_AC     = 3'd5;
  localparam logic [2:0] BLK_CR_AC     = 3'd6;
  localparam logic [2:0] BLK_RESERVED  = 3'd7;

  // DC fill wins over the skip flag; dht does not affect the entry phase.
  function automatic logic [2:0] entry_state(input logic ac_all_0, input logic skip_iq);
    if (ac_all_0)
      return ST_DCFILL;
    else if (skip_iq)
      return ST_COL;
    else
      return ST_IQ;
  endfunction

endpackage

// File: rtl/transform_seq.sv
// Per-block sequencer for the 4x4 inverse-transform register file: dequant load,
// column pass, row pass (or DC fill), then a held done_valid until acknowledged.
module transform_seq
  import transform_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  output logic       start_ready,
  input  logic [2:0] blk_type_in,
  input  logic       dht_in,
  input  logic       skip_iq_in,
  input  logic       ac_all_0_in,
  output logic [2:0] block_type,
  output logic       AC_all_0_wr,
  output logic       IQ_wr,
  output logic       DHT_wr,
  output logic       IDCT_wr,
  output logic       wr_col,
  output logic       rd_col,
  output logic [1:0] wr_idx,
  output logic [1:0] rd_idx,
  output logic       rd,
  output logic       done_valid,
  input  logic       done_ack
);

  logic [2:0] state;
  logic [1:0] idx;
  logic       dht_q;
  logic       idx_last;
  logic       in_col;
  logic       in_row;
  logic       in_pass;
  logic       in_iq;

  assign idx_last = (idx == 2'(PHASE_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      block_type <= '0;
      dht_q      <= 1'b0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            block_type <= blk_type_in;
            dht_q      <= dht_in;
            idx        <= '0;
            state      <= entry_state(ac_all_0_in, skip_iq_in);
          end
        end
        ST_DCFILL: state <= ST_DONE;
        ST_IQ: begin
          idx <= idx + 2'd1;
          if (idx_last) state <= ST_COL;
        end
        ST_COL: begin
          idx <= idx + 2'd1;
          if (idx_last) state <= ST_ROW;
        end
        ST_ROW: begin
          idx <= idx + 2'd1;
          if (idx_last) state <= ST_DONE;
        end
        ST_DONE: begin
          if (done_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output decode: registered state, idx and latched fields only; ena does not gate.
  assign in_iq   = (state == ST_IQ);
  assign in_col  = (state == ST_COL);
  assign in_row  = (state == ST_ROW);
  assign in_pass = in_col | in_row;

  assign start_ready = (state == ST_IDLE);
  assign AC_all_0_wr = (state == ST_DCFILL);
  assign IQ_wr       = in_iq;
  assign rd          = in_pass;
  assign rd_col      = in_col;
  assign wr_col      = in_col;
  assign rd_idx      = in_pass ? idx : 2'd0;
  assign wr_idx      = (in_pass | in_iq) ? idx : 2'd0;
  assign DHT_wr      = in_pass & dht_q;
  assign IDCT_wr     = in_pass & ~dht_q;
  assign done_valid  = (state == ST_DONE);

endmodule

// File: tb/tb_transform_seq.sv
// Randomized scoreboard bench for transform_seq: a block-level model queues the
// expected output beats, a monitor compares the DUT against the queue head every cycle.
module tb_transform_seq;
  import transform_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic       start_ready;
  logic [2:0] blk_type_in = '0;
  logic       dht_in = 1'b0;
  logic       skip_iq_in = 1'b0;
  logic       ac_all_0_in = 1'b0;
  logic [2:0] block_type;
  logic       AC_all_0_wr, IQ_wr, DHT_wr, IDCT_wr, wr_col, rd_col, rd, done_valid;
  logic [1:0] wr_idx, rd_idx;
  logic       done_ack = 1'b0;

  transform_seq dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .start_ready(start_ready),
    .blk_type_in(blk_type_in), .dht_in(dht_in), .skip_iq_in(skip_iq_in),
    .ac_all_0_in(ac_all_0_in), .block_type(block_type), .AC_all_0_wr(AC_all_0_wr),
    .IQ_wr(IQ_wr), .DHT_wr(DHT_wr), .IDCT_wr(IDCT_wr), .wr_col(wr_col), .rd_col(rd_col),
    .wr_idx(wr_idx), .rd_idx(rd_idx), .rd(rd), .done_valid(done_valid), .done_ack(done_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       start_ready;
    logic [2:0] bt;
    logic       ac;
    logic       iq;
    logic       dht;
    logic       idct;
    logic       wr_col;
    logic       rd_col;
    logic [1:0] wr_idx;
    logic [1:0] rd_idx;
    logic       rd;
    logic       done;
  } vec_t;

  vec_t       sb[$];
  logic [2:0] last_bt = '0;
  int         exp_lat = 0;
  int         popped = 0;
  bit         done_seen = 1'b0;
  int         errors = 0;
  int         checks = 0;

  function automatic vec_t actual();
    vec_t v;
    v.start_ready = start_ready; v.bt = block_type; v.ac = AC_all_0_wr; v.iq = IQ_wr;
    v.dht = DHT_wr; v.idct = IDCT_wr; v.wr_col = wr_col; v.rd_col = rd_col;
    v.wr_idx = wr_idx; v.rd_idx = rd_idx; v.rd = rd; v.done = done_valid;
    return v;
  endfunction

  function automatic vec_t idle_vec(input logic [2:0] bt);
    vec_t v = '0;
    v.start_ready = 1'b1;
    v.bt = bt;
    return v;
  endfunction

  task automatic check_vec(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the whole block as a list of beats, one per ena-qualified cycle.
  task automatic push_block(input logic ac, input logic skip, input logic dht, input logic [2:0] bt);
    vec_t v;
    last_bt = bt;
    popped = 0;
    done_seen = 1'b0;
    if (ac) begin
      v = '0; v.bt = bt; v.ac = 1'b1;
      sb.push_back(v);
      exp_lat = 2;
    end else begin
      if (!skip)
        for (int i = 0; i < 4; i++) begin
          v = '0; v.bt = bt; v.iq = 1'b1; v.wr_idx = 2'(i);
          sb.push_back(v);
        end
      for (int pass = 0; pass < 2; pass++)
        for (int i = 0; i < 4; i++) begin
          v = '0; v.bt = bt; v.rd = 1'b1;
          v.rd_col = (pass == 0); v.wr_col = (pass == 0);
          v.rd_idx = 2'(i); v.wr_idx = 2'(i);
          v.dht = dht; v.idct = !dht;
          sb.push_back(v);
        end
      exp_lat = skip ? 9 : 13;
    end
    v = '0; v.bt = bt; v.done = 1'b1;
    sb.push_back(v);
  endtask

  // Monitor: outputs must equal the pending beat; a beat is consumed on ena (done needs ack too).
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() == 0) begin
        check_vec("idle_outputs", actual(), idle_vec(last_bt));
      end else begin
        check_vec("block_beat", actual(), sb[0]);
        if (sb[0].done && !done_seen) begin
          done_seen = 1'b1;
          check_int("done_latency", popped + 1, exp_lat);
        end
        if (ena) begin
          if (!sb[0].done) begin
            void'(sb.pop_front());
            popped++;
          end else if (done_ack) begin
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic do_block(input logic ac, input logic skip, input logic dht, input logic [2:0] bt,
                          input int stall_at, input int stall_len, input int ack_wait,
                          input int abort_at, input int ena_pct);
    int guard;
    int cyc;
    int dvn;
    guard = 0;
    while (!start_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!start_ready) begin
      errors++;
      $display("FAIL ready_timeout: start_ready=%0b required 1", start_ready);
      return;
    end
    start = 1'b1; ena = 1'b1; blk_type_in = bt; dht_in = dht;
    skip_iq_in = skip; ac_all_0_in = ac; done_ack = 1'($urandom_range(1));
    @(posedge clk);
    push_block(ac, skip, dht, bt);
    #1;
    cyc = 0;
    dvn = 0;
    while (sb.size() > 0 && cyc < 400) begin
      cyc++;
      if (cyc >= stall_at && cyc < stall_at + stall_len)
        ena = 1'b0;
      else
        ena = ($urandom_range(99) < ena_pct);
      if (done_valid) dvn++;
      done_ack = done_valid ? (dvn > ack_wait) : 1'($urandom_range(1));
      start = start_ready ? 1'b0 : 1'($urandom_range(1));
      blk_type_in = 3'($urandom_range(7));
      dht_in = 1'($urandom_range(1));
      skip_iq_in = 1'($urandom_range(1));
      ac_all_0_in = 1'($urandom_range(1));
      if (cyc == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check_vec("reset_abort_outputs", actual(), idle_vec(3'd0));
        sb.delete();
        last_bt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1; ena = 1'b1; start = 1'b0; done_ack = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL block_timeout: %0d beats left, required 0", sb.size());
      sb.delete();
    end
    start = 1'b0;
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset_outputs", actual(), idle_vec(3'd0));
    rst_n = 1'b1;
    ena = 1'b1;
    @(posedge clk); #1;

    do_block(1'b0, 1'b0, 1'b0, BLK_LUMA_4X4, 0, 0, 0, 0, 100);   // full IDCT
    do_block(1'b0, 1'b1, 1'b1, BLK_LUMA_DC, 0, 0, 0, 0, 100);    // Hadamard, skip IQ
    do_block(1'b1, 1'b1, 1'b1, BLK_CB_DC, 0, 0, 0, 0, 100);      // DC fill priority
    do_block(1'b0, 1'b0, 1'b0, BLK_CR_AC, 7, 3, 0, 0, 100);      // stall at COL idx 2
    do_block(1'b0, 1'b1, 1'b0, BLK_LUMA_AC, 0, 0, 5, 0, 100);    // ack withheld
    do_block(1'b0, 1'b0, 1'b0, BLK_CB_AC, 0, 0, 0, 6, 100);      // reset abort at cycle 6
    @(negedge clk);
    check_vec("after_abort_idle", actual(), idle_vec(3'd0));
    @(posedge clk); #1;
    do_block(1'b0, 1'b0, 1'b0, BLK_LUMA_4X4, 0, 0, 0, 0, 100);

    for (int n = 0; n < 40; n++)
      do_block(1'($urandom_range(3) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
               3'($urandom_range(7)), 0, 0, int'($urandom_range(3)), 0, 75);

    start = 1'b0;
    ena = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/transform_seq.md
# transform_seq

Sequencer for the 4x4 inverse-transform register file in the residual path. Per accepted block it drives the strobes and indices of the transform register file (dequant load, column butterfly pass, row butterfly pass with rounding, or the all-zero-AC DC fill) and signals completion through a valid/ack handshake. It sits between the residual/CAVLC control and the transform register file plus butterfly unit, and owns none of the data.

## Interface
Parameters: none.

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  global stall; when 0, all state and counters hold
- start  in  1  request to process one block; accepted only when start_ready=1
- start_ready  out  1  1 iff state IDLE
- blk_type_in  in  3  block type, latched on accept
- dht_in  in  1  1 = Hadamard (DC) transform, 0 = 4x4 IDCT; latched
- skip_iq_in  in  1  1 = register file already loaded, skip IQ phase; latched
- ac_all_0_in  in  1  1 = AC all zero: DC-fill path only; latched
- block_type  out  3  latched blk_type_in
- AC_all_0_wr  out  1  DC fill strobe
- IQ_wr  out  1  dequant row/column load strobe
- DHT_wr, IDCT_wr  out  1 each  butterfly write strobes
- wr_col, rd_col  out  1 each  column-orientation select
- wr_idx, rd_idx  out  2 each  row/column index
- rd  out  1  read enable for the register file
- done_valid  out  1  block finished; held until done_ack
- done_ack  in  1  consumer acknowledge

## Operation
- States: IDLE, DCFILL, IQ, COL, ROW, DONE. 2-bit idx counter.
- IDLE: when ena & start, latch the inputs and set idx=0. Next state is DCFILL if ac_all_0_in; otherwise COL if skip_iq_in; otherwise IQ.
- DCFILL: AC_all_0_wr=1 for one cycle, then DONE.
- IQ: IQ_wr=1, wr_idx=idx. idx goes 0..3, then COL.
- COL: rd=1, rd_col=1, rd_idx=idx; wr_col=1, wr_idx=idx; DHT_wr=dht, IDCT_wr=~dht. idx 0..3, then ROW.
- ROW: rd=1, rd_col=0, rd_idx=idx; wr_col=0, wr_idx=idx; DHT_wr/IDCT_wr as in COL. The register file applies (x+32)>>>6 on the IDCT row writes. idx 0..3, then DONE.
- Columns always run before rows, so rounding is applied on the final pass.
- DONE: done_valid=1. On ena & done_ack, go to IDLE. A start in DONE is ignored, not queued.
- Every strobe, index and select is decoded only from registered state, idx and latched fields. There is no combinational path from start, done_ack or the *_in ports to any output.
- Strobes are not gated by ena. The register file gates them itself, and the FSM freezes with them.
- idx wraps 3→0 on the phase transition. idx resets to 0 on every accept.

## Timing
- Reset: all outputs 0 (start_ready=1 after reset deassertion since IDLE), block_type=0, idx=0, state IDLE.
- Latency, counting the accept edge as cycle 0 (cycles with ena=1 only):
  - full IDCT: IQ in cycles 1–4, COL 5–8, ROW 9–12, done_valid from cycle 13.
  - skip_iq: done_valid from cycle 9.
  - DC fill: strobe in cycle 1, done_valid from cycle 2.
- done_ack in the first done_valid cycle: IDLE (start_ready=1) the next cycle. The minimum block-to-block spacing is latency+1.
- ena=0 mid-phase: outputs hold their current values. idx does not advance. The phase resumes unchanged when ena returns.
- rst_n asserted mid-block: immediate return to IDLE, all strobes 0. No done_valid for the aborted block.
- ac_all_0_in has priority over skip_iq_in and dht_in.

## Structure
- Package transform_pkg holds:
  - the state enumeration (3-bit);
  - phase length constant 4;
  - block_type codes shared with the register file.
- Single module with no sub-modules: FSM, idx counter and output decode together are about 150–250 lines.

## Test plan
- Reset, then IDCT start with skip_iq=0, dht=0 → IQ_wr with wr_idx 0,1,2,3 in cycles 1–4; COL with rd_col=wr_col=1 and IDCT_wr in 5–8; ROW with wr_col=0 in 9–12; done_valid at 13. The golden 4x4 result matches through a connected register file and butterfly.
- dht=1, skip_iq=1 → DHT_wr in cycles 1–8, IDCT_wr never 1, IQ_wr never 1, done_valid at 9.
- ac_all_0=1 (also dht=1, skip_iq=1) → exactly one AC_all_0_wr pulse at cycle 1, no rd, done_valid at 2. With curr_DC=100, all 16 rounding outputs equal 2.
- ena low for 3 cycles at COL idx=2 → outputs frozen for those 3 cycles; total latency extends by 3; result is identical.
- start asserted during ROW and during DONE → ignored, start_ready=0. done_ack withheld 5 cycles → done_valid stays high 5+ cycles, then IDLE one cycle after ack.
- rst_n pulsed low at cycle 6 of an IDCT → all outputs 0 asynchronously, IDLE after release. A new block then completes with the normal 13-cycle latency.
